control_fsm: RTL and testbench

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/control_fsm.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_control_fsm.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_fsm.sv
// control_fsm -- multi-cycle instruction sequencer for a 16-bit datapath.
//
// Walks each instruction through FETCH -> DECODE -> EXEC/MEM -> WB and drives
// the datapath enables, mux selects and memory strobes for every step. Memory
// waits are bounded by WAIT_MAX cycles; overrunning that bound parks the block
// in FAULT until reset.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   instruction    [15:0] word from memory; opcode [15:12], extension [7:4]
//   memReady       memory completion handshake
//   memRead/Write  memory request strobes (mutually exclusive)
//   irS .. pcRegMuxEn  single-bit datapath enables
//   aluControl     [3:0] ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 CMP
//   mux4En         [1:0] ALU B operand: 00 register, 01 immediate
//   exMemResultEn  [1:0] write-back source: 00 ALU/shift, 01 memory, 10 move
//   regpcCont      [1:0] address source: 01 PC (fetch), 00 register (data)
//   state          [2:0] current state code; fault sticky fault flag
module control_fsm #(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  logic        memReady,
  output logic        memRead,
  output logic        memWrite,
  output logic        irS,
  output logic        srcRegEn,
  output logic        dstRegEn,
  output logic        immRegEn,
  output logic        resultRegEn,
  output logic        regFileEn,
  output logic        pcRegEn,
  output logic        signEn,
  output logic        shiftALUMuxEn,
  output logic        regImmMuxEn,
  output logic        pcRegMuxEn,
  output logic [3:0]  aluControl,
  output logic [1:0]  mux4En,
  output logic [1:0]  exMemResultEn,
  output logic [1:0]  regpcCont,
  output logic [2:0]  state,
  output logic        fault
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    FAULT  = 3'd5
  } state_t;

  // Everything the later states need to know about the fetched instruction.
  typedef struct packed {
    logic       valid;
    logic       mem;
    logic       stor;
    logic       cmp;
    logic [3:0] alu;
    logic [1:0] mux4;
    logic       sign;
    logic       shift;
    logic       regimm;
    logic [1:0] wbsel;
  } dec_t;

  // Registered control outputs.
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       src_en;
    logic       dst_en;
    logic       imm_en;
    logic       result_en;
    logic       regfile_en;
    logic       pc_en;
    logic       sign_en;
    logic       shift_en;
    logic       regimm_en;
    logic [3:0] alu;
    logic [1:0] mux4;
    logic [1:0] exmem;
    logic [1:0] regpc;
    logic       fault;
  } ctl_t;

  function automatic dec_t decode(input logic [3:0] op, input logic [3:0] ext);
    dec_t       d;
    logic [3:0] sel;
    logic [3:0] alu;
    logic       sel_ok;
    d      = '0;
    // R-type selects the ALU op by extension, immediates by opcode; both
    // use the same code points.
    sel    = (op == 4'b0000) ? ext : op;
    sel_ok = 1'b1;
    alu    = 4'd0;
    case (sel)
      4'b0101: alu = 4'd0;
      4'b1001: alu = 4'd1;
      4'b0001: alu = 4'd2;
      4'b0010: alu = 4'd3;
      4'b0011: alu = 4'd4;
      4'b1011: alu = 4'd5;
      default: sel_ok = 1'b0;
    endcase
    case (op)
      4'b0000: begin
        if (ext == 4'b1101) begin
          d.valid = 1'b1;
          d.wbsel = 2'b10;
        end else if (sel_ok) begin
          d.valid = 1'b1;
          d.alu   = alu;
          d.cmp   = (ext == 4'b1011);
        end
      end
      4'b1101: begin
        d.valid = 1'b1;
        d.mux4  = 2'b01;
        d.wbsel = 2'b10;
      end
      4'b1000: begin
        if (ext == 4'b0100) begin
          d.valid = 1'b1;
          d.shift = 1'b1;
        end else if (ext[3:1] == 3'b000) begin
          d.valid  = 1'b1;
          d.shift  = 1'b1;
          d.regimm = 1'b1;
          d.sign   = 1'b1;
        end
      end
      4'b0100: begin
        if (ext == 4'b0000) begin
          d.valid = 1'b1;
          d.mem   = 1'b1;
          d.wbsel = 2'b01;
        end else if (ext == 4'b0100) begin
          d.valid = 1'b1;
          d.mem   = 1'b1;
          d.stor  = 1'b1;
        end
      end
      default: begin
        if (sel_ok) begin
          d.valid = 1'b1;
          d.alu   = alu;
          d.mux4  = 2'b01;
          // Logical immediates are zero-extended.
          d.sign  = !(alu == 4'd2 || alu == 4'd3 || alu == 4'd4);
          d.cmp   = (op == 4'b1011);
        end
      end
    endcase
    return d;
  endfunction

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  dec_t          dec_reg, dec_next, dec_in;
  ctl_t          ctl_reg, ctl_next;
  logic          mem_done;
  logic          wait_expired;
  logic          unused_instr_bits;

  assign dec_in            = decode(instruction[15:12], instruction[7:4]);
  assign unused_instr_bits = ^{instruction[11:8], instruction[3:0]};

  // The first MEM cycle presents the address only; memReady is honoured from
  // the second cycle so a handshake still high from the instruction fetch
  // cannot complete the data access.
  assign mem_done     = (state_reg == MEM) && (cnt_reg != '0) && memReady;
  assign wait_expired = (cnt_reg == CW'(WAIT_MAX - 1));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dec_next   = dec_reg;
    ctl_next   = '0;

    case (state_reg)
      FETCH: begin
        // mem_read low here means the cycle right after reset: the fetch
        // request has not been issued yet, so nothing can complete.
        if (ctl_reg.mem_read) begin
          if (memReady) begin
            state_next = DECODE;
            dec_next   = dec_in;
          end else if (wait_expired) begin
            state_next = FAULT;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      DECODE: begin
        if (!dec_reg.valid)   state_next = FETCH;
        else if (dec_reg.mem) state_next = MEM;
        else                  state_next = EXEC;
      end
      EXEC:    state_next = dec_reg.cmp ? FETCH : WB;
      MEM: begin
        if (mem_done)          state_next = dec_reg.stor ? FETCH : WB;
        else if (wait_expired) state_next = FAULT;
        else                   cnt_next = cnt_reg + 1'b1;
      end
      WB:      state_next = FETCH;
      FAULT:   state_next = FAULT;
      default: state_next = FETCH;
    endcase

    if ((state_next == FETCH || state_next == MEM) && state_next != state_reg)
      cnt_next = '0;

    // Outputs are registered, so they are decoded from the state being entered.
    case (state_next)
      FETCH: begin
        ctl_next.mem_read = 1'b1;
        ctl_next.regpc    = 2'b01;
      end
      DECODE: begin
        ctl_next.src_en = 1'b1;
        ctl_next.dst_en = 1'b1;
        ctl_next.imm_en = 1'b1;
        ctl_next.pc_en  = !dec_next.valid;  // undefined: retire as NOP
      end
      EXEC: begin
        ctl_next.result_en = 1'b1;
        ctl_next.alu       = dec_reg.alu;
        ctl_next.mux4      = dec_reg.mux4;
        ctl_next.sign_en   = dec_reg.sign;
        ctl_next.shift_en  = dec_reg.shift;
        ctl_next.regimm_en = dec_reg.regimm;
        ctl_next.pc_en     = dec_reg.cmp;
      end
      MEM: begin
        ctl_next.mem_read  = !dec_reg.stor;
        ctl_next.mem_write = dec_reg.stor;
        ctl_next.regpc     = 2'b00;
      end
      WB: begin
        ctl_next.regfile_en = 1'b1;
        ctl_next.pc_en      = 1'b1;
        ctl_next.exmem      = dec_reg.wbsel;
      end
      FAULT:   ctl_next.fault = 1'b1;
      default: ctl_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= FETCH;
      cnt_reg   <= '0;
      dec_reg   <= '0;
      ctl_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dec_reg   <= dec_next;
      ctl_reg   <= ctl_next;
    end
  end

  // irS and the store-completion pcRegEn qualify on the live handshake; both
  // terms are gated by registers that reset asynchronously.
  assign irS           = (state_reg == FETCH) && ctl_reg.mem_read && memReady;
  assign pcRegEn       = ctl_reg.pc_en || (mem_done && dec_reg.stor);
  assign memRead       = ctl_reg.mem_read;
  assign memWrite      = ctl_reg.mem_write;
  assign srcRegEn      = ctl_reg.src_en;
  assign dstRegEn      = ctl_reg.dst_en;
  assign immRegEn      = ctl_reg.imm_en;
  assign resultRegEn   = ctl_reg.result_en;
  assign regFileEn     = ctl_reg.regfile_en;
  assign signEn        = ctl_reg.sign_en;
  assign shiftALUMuxEn = ctl_reg.shift_en;
  assign regImmMuxEn   = ctl_reg.regimm_en;
  assign pcRegMuxEn    = 1'b0;
  assign aluControl    = ctl_reg.alu;
  assign mux4En        = ctl_reg.mux4;
  assign exMemResultEn = ctl_reg.exmem;
  assign regpcCont     = ctl_reg.regpc;
  assign state         = state_reg;
  assign fault         = ctl_reg.fault;

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic        memReady;
  logic        memRead, memWrite, irS, srcRegEn, dstRegEn, immRegEn;
  logic        resultRegEn, regFileEn, pcRegEn, signEn, shiftALUMuxEn;
  logic        regImmMuxEn, pcRegMuxEn, fault;
  logic [3:0]  aluControl;
  logic [1:0]  mux4En, exMemResultEn, regpcCont;
  logic [2:0]  state;

  int pass_cnt = 0;
  int total    = 0;

  control_fsm #(.WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .memReady(memReady),
    .memRead(memRead), .memWrite(memWrite), .irS(irS), .srcRegEn(srcRegEn),
    .dstRegEn(dstRegEn), .immRegEn(immRegEn), .resultRegEn(resultRegEn),
    .regFileEn(regFileEn), .pcRegEn(pcRegEn), .signEn(signEn),
    .shiftALUMuxEn(shiftALUMuxEn), .regImmMuxEn(regImmMuxEn),
    .pcRegMuxEn(pcRegMuxEn), .aluControl(aluControl), .mux4En(mux4En),
    .exMemResultEn(exMemResultEn), .regpcCont(regpcCont), .state(state),
    .fault(fault)
  );

  always #5 clk = ~clk;

  wire [22:0] all_ctl = {memRead, memWrite, irS, srcRegEn, dstRegEn, immRegEn,
                         resultRegEn, regFileEn, pcRegEn, signEn, shiftALUMuxEn,
                         regImmMuxEn, pcRegMuxEn, aluControl, mux4En,
                         exMemResultEn, regpcCont};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; memReady = 1'b0; instruction = 16'h0000;
    #2 reset = 1'b0;
    #1;
    total++; if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state); else pass_cnt++;
    total++; if (fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", fault); else pass_cnt++;
    total++; if (all_ctl !== 23'd0) $display("FAIL reset_outputs: got %h want 0", all_ctl); else pass_cnt++;
    tick;
    total++; if (all_ctl !== 23'd0 || state !== 3'd0) $display("FAIL reset_held: got ctl=%h st=%0d want 0/0", all_ctl, state); else pass_cnt++;
    reset = 1'b1;
    tick;
    total++; if ({state, memRead, regpcCont} !== {3'd0, 1'b1, 2'b01})
      $display("FAIL reset_first_fetch: got st=%0d rd=%b pc=%b want 0/1/01", state, memRead, regpcCont);
    else pass_cnt++;
    $display("reset: state=%0d memRead=%b", state, memRead);
  endtask

  task automatic test_add;
    instruction = 16'h0251; memReady = 1'b1;
    #1;
    total++; if (irS !== 1'b1) $display("FAIL add_irs: got %b want 1", irS); else pass_cnt++;
    tick;
    total++; if ({state, srcRegEn, dstRegEn, immRegEn, pcRegEn, irS} !== {3'd1, 3'b111, 2'b00})
      $display("FAIL add_decode: got st=%0d en=%b%b%b pc=%b irs=%b want 1/111/0/0", state, srcRegEn, dstRegEn, immRegEn, pcRegEn, irS);
    else pass_cnt++;
    tick;
    total++; if ({state, aluControl, resultRegEn, regFileEn, pcRegEn} !== {3'd2, 4'd0, 3'b100})
      $display("FAIL add_exec: got st=%0d alu=%h res=%b rf=%b pc=%b want 2/0/1/0/0", state, aluControl, resultRegEn, regFileEn, pcRegEn);
    else pass_cnt++;
    tick;
    total++; if ({state, regFileEn, pcRegEn, exMemResultEn} !== {3'd4, 2'b11, 2'b00})
      $display("FAIL add_wb: got st=%0d rf=%b pc=%b ex=%b want 4/1/1/00", state, regFileEn, pcRegEn, exMemResultEn);
    else pass_cnt++;
    tick;
    total++; if ({state, memRead, regFileEn, pcRegEn} !== {3'd0, 3'b100})
      $display("FAIL add_return: got st=%0d rd=%b rf=%b pc=%b want 0/1/0/0", state, memRead, regFileEn, pcRegEn);
    else pass_cnt++;
    $display("add: returned to state %0d", state);
  endtask

  task automatic test_cmpi;
    instruction = 16'hB1FF; memReady = 1'b1;
    tick;
    total++; if (state !== 3'd1) $display("FAIL cmpi_decode: got %0d want 1", state); else pass_cnt++;
    tick;
    total++; if ({state, aluControl, mux4En, signEn, pcRegEn, regFileEn} !== {3'd2, 4'd5, 2'b01, 3'b110})
      $display("FAIL cmpi_exec: got st=%0d alu=%h mux=%b s=%b pc=%b rf=%b want 2/5/01/1/1/0", state, aluControl, mux4En, signEn, pcRegEn, regFileEn);
    else pass_cnt++;
    tick;
    total++; if ({state, regFileEn, memRead} !== {3'd0, 1'b0, 1'b1})
      $display("FAIL cmpi_return: got st=%0d rf=%b rd=%b want 0/0/1", state, regFileEn, memRead);
    else pass_cnt++;
    $display("cmpi: returned to state %0d", state);
  endtask

  task automatic test_load_wait;
    int n = 0;
    int wr = 0;
    instruction = 16'h4100; memReady = 1'b1;
    tick;
    total++; if (state !== 3'd1) $display("FAIL load_decode: got %0d want 1", state); else pass_cnt++;
    memReady = 1'b0;
    tick;
    total++; if ({state, regpcCont} !== {3'd3, 2'b00}) $display("FAIL load_mem_entry: got st=%0d pc=%b want 3/00", state, regpcCont); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      if (state !== 3'd3) break;
      if (memRead) n++;
      if (memWrite) wr++;
      if (n == 4) memReady = 1'b1;
      tick;
    end
    total++; if (n !== 4) $display("FAIL load_read_cycles: got %0d want 4", n); else pass_cnt++;
    total++; if (wr !== 0) $display("FAIL load_no_write: got %0d want 0", wr); else pass_cnt++;
    total++; if ({state, exMemResultEn, regFileEn, memRead} !== {3'd4, 2'b01, 2'b10})
      $display("FAIL load_wb: got st=%0d ex=%b rf=%b rd=%b want 4/01/1/0", state, exMemResultEn, regFileEn, memRead);
    else pass_cnt++;
    tick;
    total++; if (state !== 3'd0) $display("FAIL load_return: got %0d want 0", state); else pass_cnt++;
    $display("load: memRead held %0d cycles", n);
  endtask

  task automatic test_decode;
    // {alu, mux4, sign, shift, regimm} expected in EXEC, then exMem in WB
    logic [15:0] ins [8] = '{16'h0192, 16'h2345, 16'h5A7F, 16'h0432,
                             16'h01D2, 16'hD3FF, 16'h8141, 16'h8213};
    logic [8:0]  ex  [8] = '{9'b0001_00_000, 9'b0011_01_000, 9'b0000_01_100, 9'b0100_00_000,
                             9'b0000_00_000, 9'b0000_01_000, 9'b0000_00_010, 9'b0000_00_111};
    logic [1:0]  wb  [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
    for (int i = 0; i < 8; i++) begin
      instruction = ins[i]; memReady = 1'b1;
      tick; tick;
      total++; if ({state, aluControl, mux4En, signEn, shiftALUMuxEn, regImmMuxEn} !== {3'd2, ex[i]})
        $display("FAIL decode_exec_%h: got st=%0d fields=%b want 2/%b", ins[i], state,
                 {aluControl, mux4En, signEn, shiftALUMuxEn, regImmMuxEn}, ex[i]);
      else pass_cnt++;
      tick;
      total++; if ({state, exMemResultEn} !== {3'd4, wb[i]})
        $display("FAIL decode_wb_%h: got st=%0d ex=%b want 4/%b", ins[i], state, exMemResultEn, wb[i]);
      else pass_cnt++;
      tick;
      $display("decode %h: alu=%0d mux4=%b sign=%b wbsel=%b", ins[i], aluControl, mux4En, signEn, wb[i]);
    end
  endtask

  task automatic test_latency;
    logic [15:0] ins [5] = '{16'h0251, 16'h02B1, 16'h4100, 16'h4140, 16'h1234};
    int          lat [5] = '{4, 3, 5, 4, 4};
    int          rfw [5] = '{1, 0, 1, 0, 1};
    for (int i = 0; i < 5; i++) begin
      int cyc = 0;
      int pcn = 0;
      int rfn = 0;
      int ov  = 0;
      instruction = ins[i]; memReady = 1'b1;
      do begin
        cyc++;
        if (memRead && memWrite) ov++;
        if (pcRegEn) pcn++;
        if (regFileEn) rfn++;
        tick;
      end while (state !== 3'd0 && cyc < 20);
      total++; if (cyc !== lat[i]) $display("FAIL latency_%h: got %0d want %0d", ins[i], cyc, lat[i]); else pass_cnt++;
      total++; if (pcn !== 1) $display("FAIL pc_once_%h: got %0d want 1", ins[i], pcn); else pass_cnt++;
      total++; if (rfn !== rfw[i]) $display("FAIL regfile_%h: got %0d want %0d", ins[i], rfn, rfw[i]); else pass_cnt++;
      total++; if (ov !== 0) $display("FAIL rw_exclusive_%h: got %0d want 0", ins[i], ov); else pass_cnt++;
      $display("latency %h: %0d cycles", ins[i], cyc);
    end
  endtask

  task automatic test_undefined;
    logic [15:0] ins [3] = '{16'hF000, 16'h4120, 16'h0070};
    for (int i = 0; i < 3; i++) begin
      instruction = ins[i]; memReady = 1'b1;
      tick;
      total++; if ({state, pcRegEn, fault} !== {3'd1, 2'b10})
        $display("FAIL undef_decode_%h: got st=%0d pc=%b f=%b want 1/1/0", ins[i], state, pcRegEn, fault);
      else pass_cnt++;
      tick;
      total++; if ({state, memRead, pcRegEn, fault} !== {3'd0, 3'b100})
        $display("FAIL undef_return_%h: got st=%0d rd=%b pc=%b f=%b want 0/1/0/0", ins[i], state, memRead, pcRegEn, fault);
      else pass_cnt++;
      $display("undefined %h: back to state %0d", ins[i], state);
    end
  endtask

  task automatic test_wait_boundary;
    instruction = 16'h0251; memReady = 1'b0;
    for (int i = 0; i < 14; i++) tick;
    total++; if ({state, memRead} !== {3'd0, 1'b1}) $display("FAIL boundary_still_fetch: got st=%0d rd=%b want 0/1", state, memRead); else pass_cnt++;
    memReady = 1'b1;
    tick;
    total++; if ({state, fault} !== {3'd1, 1'b0}) $display("FAIL boundary_ready_wins: got st=%0d f=%b want 1/0", state, fault); else pass_cnt++;
    tick; tick; tick;
    total++; if (state !== 3'd0) $display("FAIL boundary_return: got %0d want 0", state); else pass_cnt++;
    $display("wait boundary: ready on 15th cycle accepted");
  endtask

  task automatic test_fault;
    int n = 0;
    instruction = 16'h0000; memReady = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (state !== 3'd0) break;
      if (memRead) n++;
      tick;
    end
    total++; if (n !== 15) $display("FAIL fault_fetch_cycles: got %0d want 15", n); else pass_cnt++;
    total++; if ({state, fault, all_ctl} !== {3'd5, 1'b1, 23'd0})
      $display("FAIL fault_entry: got st=%0d f=%b ctl=%h want 5/1/0", state, fault, all_ctl);
    else pass_cnt++;
    memReady = 1'b1;
    tick; tick;
    total++; if ({state, fault, all_ctl} !== {3'd5, 1'b1, 23'd0})
      $display("FAIL fault_sticky: got st=%0d f=%b ctl=%h want 5/1/0", state, fault, all_ctl);
    else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    total++; if ({state, fault} !== {3'd0, 1'b0}) $display("FAIL fault_reset_clear: got st=%0d f=%b want 0/0", state, fault); else pass_cnt++;
    #1 reset = 1'b1;
    tick;
    total++; if ({state, memRead} !== {3'd0, 1'b1}) $display("FAIL fault_restart: got st=%0d rd=%b want 0/1", state, memRead); else pass_cnt++;
    $display("fault: entered after %0d fetch cycles, cleared by reset", n);
  endtask

  task automatic test_reset_mid_stor;
    instruction = 16'h4140; memReady = 1'b1;
    tick;
    memReady = 1'b0;
    tick;
    total++; if ({state, memWrite, memRead} !== {3'd3, 2'b10}) $display("FAIL stor_mem: got st=%0d wr=%b rd=%b want 3/1/0", state, memWrite, memRead); else pass_cnt++;
    tick;
    #2 reset = 1'b0;
    #1;
    total++; if ({state, all_ctl} !== {3'd0, 23'd0}) $display("FAIL stor_async_reset: got st=%0d ctl=%h want 0/0", state, all_ctl); else pass_cnt++;
    #1 reset = 1'b1;
    memReady = 1'b1;
    tick;
    total++; if ({state, memRead, memWrite} !== {3'd0, 2'b10}) $display("FAIL stor_restart: got st=%0d rd=%b wr=%b want 0/1/0", state, memRead, memWrite); else pass_cnt++;
    $display("stor reset: memWrite dropped, restart at state %0d", state);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_cmpi();
    test_load_wait();
    test_decode();
    test_latency();
    test_undefined();
    test_wait_boundary();
    test_fault();
    test_reset_mid_stor();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
